// File: rtl/y86_decode_regfile.sv
// Y86-64 decode/write-back stage: 15-entry register file, operand decode and registered decode outputs.
// Optional same-cycle write-back forwarding into the read path: define YRF_WRITE_THROUGH_EN.
module y86_decode_regfile #(
    parameter int N      = 64,
    parameter int NREG   = 15,
    parameter int RSP_ID = 4
) (
    input  logic         clk_i,
    input  logic         reset_ni,
    input  logic         in_valid_i,
    input  logic         stall_i,
    input  logic [3:0]   icode_i,
    input  logic [3:0]   ifun_i,
    input  logic [3:0]   rA_i,
    input  logic [3:0]   rB_i,
    input  logic         wb_valid_i,
    input  logic [3:0]   wb_icode_i,
    input  logic [3:0]   wb_dstE_i,
    input  logic [3:0]   wb_dstM_i,
    input  logic [N-1:0] wb_valE_i,
    input  logic [N-1:0] wb_valM_i,
    input  logic         wb_cnd_i,
    output logic         out_valid_o,
    output logic [3:0]   out_icode_o,
    output logic [3:0]   out_ifun_o,
    output logic [N-1:0] valA_o,
    output logic [N-1:0] valB_o,
    output logic [3:0]   dstE_o,
    output logic [3:0]   dstM_o,
    output logic         halted_o
);

    localparam logic [3:0] RNONE    = 4'hF;
    localparam logic [3:0] RSP      = 4'(RSP_ID);

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [N-1:0] regs_q [NREG];
    logic [N-1:0] regs_d [NREG];

    logic         out_valid_q, out_valid_d;
    logic [3:0]   out_icode_q, out_icode_d;
    logic [3:0]   out_ifun_q,  out_ifun_d;
    logic [N-1:0] valA_q,      valA_d;
    logic [N-1:0] valB_q,      valB_d;
    logic [3:0]   dstE_q,      dstE_d;
    logic [3:0]   dstM_q,      dstM_d;

    logic [3:0]   src_a, src_b, dec_dstE, dec_dstM;
    logic [N-1:0] rd_a, rd_b;
    logic         e_we, m_we;

    always_comb begin
        src_a = RNONE;
        case (icode_i)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = rA_i;
            I_RET, I_POPQ:                      src_a = RSP;
            default:                            src_a = RNONE;
        endcase
    end

    always_comb begin
        src_b = RNONE;
        case (icode_i)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:     src_b = rB_i;
            I_CALL, I_RET, I_PUSHQ, I_POPQ: src_b = RSP;
            default:                        src_b = RNONE;
        endcase
    end

    always_comb begin
        dec_dstE = RNONE;
        case (icode_i)
            I_RRMOVQ, I_IRMOVQ, I_OPQ:      dec_dstE = rB_i;
            I_CALL, I_RET, I_PUSHQ, I_POPQ: dec_dstE = RSP;
            default:                        dec_dstE = RNONE;
        endcase
    end

    always_comb begin
        dec_dstM = RNONE;
        case (icode_i)
            I_MRMOVQ, I_POPQ: dec_dstM = rA_i;
            default:          dec_dstM = RNONE;
        endcase
    end

    // A not-taken conditional move retires without touching its destination.
    assign e_we = wb_valid_i && (wb_dstE_i != RNONE)
                  && !((wb_icode_i == I_RRMOVQ) && !wb_cnd_i);
    assign m_we = wb_valid_i && (wb_dstM_i != RNONE);

    // M-port is applied last so it wins a shared destination (popq %rsp).
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (e_we && (wb_dstE_i == 4'(i))) regs_d[i] = wb_valE_i;
            if (m_we && (wb_dstM_i == 4'(i))) regs_d[i] = wb_valM_i;
        end
    end

    // ID 15 matches no entry and therefore reads as zero.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < NREG; i++) begin
`ifdef YRF_WRITE_THROUGH_EN
            if (src_a == 4'(i)) rd_a = regs_d[i];
            if (src_b == 4'(i)) rd_b = regs_d[i];
`else
            if (src_a == 4'(i)) rd_a = regs_q[i];
            if (src_b == 4'(i)) rd_b = regs_q[i];
`endif
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_icode_d = out_icode_q;
        out_ifun_d  = out_ifun_q;
        valA_d      = valA_q;
        valB_d      = valB_q;
        dstE_d      = dstE_q;
        dstM_d      = dstM_q;
        case (state_q)
            S_RUN: begin
                if (!stall_i) begin
                    if (in_valid_i) begin
                        out_valid_d = 1'b1;
                        out_icode_d = icode_i;
                        out_ifun_d  = ifun_i;
                        valA_d      = rd_a;
                        valB_d      = rd_b;
                        dstE_d      = dec_dstE;
                        dstM_d      = dec_dstM;
                        if (icode_i == I_HALT) state_d = S_HALTED;
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end
            end
            S_HALTED: begin
                out_valid_d = 1'b0;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            out_valid_q <= 1'b0;
            out_icode_q <= 4'h0;
            out_ifun_q  <= 4'h0;
            valA_q      <= '0;
            valB_q      <= '0;
            dstE_q      <= RNONE;
            dstM_q      <= RNONE;
        end else begin
            out_valid_q <= out_valid_d;
            out_icode_q <= out_icode_d;
            out_ifun_q  <= out_ifun_d;
            valA_q      <= valA_d;
            valB_q      <= valB_d;
            dstE_q      <= dstE_d;
            dstM_q      <= dstM_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_icode_o = out_icode_q;
    assign out_ifun_o  = out_ifun_q;
    assign valA_o      = valA_q;
    assign valB_o      = valB_q;
    assign dstE_o      = dstE_q;
    assign dstM_o      = dstM_q;
    assign halted_o    = (state_q == S_HALTED);

endmodule

// File: tb/tb_y86_decode_regfile.sv
// Bench for y86_decode_regfile: directed vector table, reset/halt sequences and a randomized model run.
module tb_y86_decode_regfile;
    localparam int N = 64;

`ifdef YRF_WRITE_THROUGH_EN
    localparam logic [63:0] POP_RSP = 64'h20;
`else
    localparam logic [63:0] POP_RSP = 64'h0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic         in_valid, stall, wb_valid, wb_cnd;
    logic [3:0]   icode, ifun, ra, rb, wb_icode, wb_dste, wb_dstm;
    logic [N-1:0] wb_vale, wb_valm;
    logic         out_valid, halted;
    logic [3:0]   out_icode, out_ifun, dste, dstm;
    logic [N-1:0] vala, valb;

    y86_decode_regfile #(.N(N), .NREG(15), .RSP_ID(4)) dut (
        .clk_i(clk), .reset_ni(reset_n), .in_valid_i(in_valid), .stall_i(stall),
        .icode_i(icode), .ifun_i(ifun), .rA_i(ra), .rB_i(rb),
        .wb_valid_i(wb_valid), .wb_icode_i(wb_icode), .wb_dstE_i(wb_dste), .wb_dstM_i(wb_dstm),
        .wb_valE_i(wb_vale), .wb_valM_i(wb_valm), .wb_cnd_i(wb_cnd),
        .out_valid_o(out_valid), .out_icode_o(out_icode), .out_ifun_o(out_ifun),
        .valA_o(vala), .valB_o(valb), .dstE_o(dste), .dstM_o(dstm), .halted_o(halted)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_ov, input logic [3:0] e_ic,
                           input logic [3:0] e_if, input logic [63:0] e_va, input logic [63:0] e_vb,
                           input logic [3:0] e_de, input logic [3:0] e_dm, input logic e_h);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(e_ov));
        chk({tag, ".out_icode"}, 64'(out_icode), 64'(e_ic));
        chk({tag, ".out_ifun"},  64'(out_ifun),  64'(e_if));
        chk({tag, ".valA"},      vala,           e_va);
        chk({tag, ".valB"},      valb,           e_vb);
        chk({tag, ".dstE"},      64'(dste),      64'(e_de));
        chk({tag, ".dstM"},      64'(dstm),      64'(e_dm));
        chk({tag, ".halted"},    64'(halted),    64'(e_h));
    endtask

    task automatic idle_inputs();
        in_valid = 0; stall = 0; icode = 0; ifun = 0; ra = 4'hF; rb = 4'hF;
        wb_valid = 0; wb_icode = 0; wb_dste = 4'hF; wb_dstm = 4'hF;
        wb_vale = '0; wb_valm = '0; wb_cnd = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 reset_n = 0;
        #1;
        chk_all("reset", 0, 4'h0, 4'h0, 64'h0, 64'h0, 4'hF, 4'hF, 0);
        @(negedge clk);
        reset_n = 1;
    endtask

    typedef struct {
        logic        iv, st;
        logic [3:0]  ic, ifn, ra, rb;
        logic        wv;
        logic [3:0]  wic, wde, wdm;
        logic [63:0] wve, wvm;
        logic        wc;
        logic        e_ov;
        logic [3:0]  e_ic, e_if;
        logic [63:0] e_va, e_vb;
        logic [3:0]  e_de, e_dm;
        logic        e_h;
    } vec_t;

    vec_t tbl[$];

    // ---------------- behavioural reference model ----------------
    logic [63:0] m_regs [16];
    logic        m_ov, m_h;
    logic [3:0]  m_ic, m_if, m_de, m_dm;
    logic [63:0] m_va, m_vb;

    function automatic logic [3:0] f_src_a(input logic [3:0] ic, input logic [3:0] a);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return a;
        if (ic inside {4'h9, 4'hB}) return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] f_src_b(input logic [3:0] ic, input logic [3:0] b);
        if (ic inside {4'h4, 4'h5, 4'h6}) return b;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] f_dst_e(input logic [3:0] ic, input logic [3:0] b);
        if (ic inside {4'h2, 4'h3, 4'h6}) return b;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] f_dst_m(input logic [3:0] ic, input logic [3:0] a);
        if (ic inside {4'h5, 4'hB}) return a;
        return 4'hF;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_ov = 0; m_h = 0; m_ic = 0; m_if = 0; m_de = 4'hF; m_dm = 4'hF; m_va = '0; m_vb = '0;
    endtask

    // Applies one clock edge worth of architectural effect using the current inputs.
    task automatic model_step();
        logic [63:0] nr [16];
        logic [63:0] rd [16];
        nr = m_regs;
        if (wb_valid) begin
            if (wb_dste != 4'hF && !(wb_icode == 4'h2 && !wb_cnd)) nr[wb_dste] = wb_vale;
            if (wb_dstm != 4'hF) nr[wb_dstm] = wb_valm;
        end
`ifdef YRF_WRITE_THROUGH_EN
        rd = nr;
`else
        rd = m_regs;
`endif
        if (m_h) begin
            m_ov = 0;
        end else if (!stall) begin
            if (in_valid) begin
                m_ov = 1; m_ic = icode; m_if = ifun;
                m_va = rd[f_src_a(icode, ra)];
                m_vb = rd[f_src_b(icode, rb)];
                m_de = f_dst_e(icode, rb);
                m_dm = f_dst_m(icode, ra);
                if (icode == 4'h0) m_h = 1;
            end else begin
                m_ov = 0;
            end
        end
        m_regs = nr;
    endtask

    task automatic add(input logic iv, st, input logic [3:0] ic, ifn, a, b,
                       input logic wv, input logic [3:0] wic, wde, wdm,
                       input logic [63:0] wve, wvm, input logic wc,
                       input logic e_ov, input logic [3:0] e_ic, e_if,
                       input logic [63:0] e_va, e_vb, input logic [3:0] e_de, e_dm,
                       input logic e_h);
        vec_t v;
        v.iv = iv; v.st = st; v.ic = ic; v.ifn = ifn; v.ra = a; v.rb = b;
        v.wv = wv; v.wic = wic; v.wde = wde; v.wdm = wdm; v.wve = wve; v.wvm = wvm; v.wc = wc;
        v.e_ov = e_ov; v.e_ic = e_ic; v.e_if = e_if; v.e_va = e_va; v.e_vb = e_vb;
        v.e_de = e_de; v.e_dm = e_dm; v.e_h = e_h;
        tbl.push_back(v);
    endtask

    initial begin
        idle_inputs();
        reset_n = 0;
        #12;
        reset_n = 1;
        chk_all("por", 0, 4'h0, 4'h0, 64'h0, 64'h0, 4'hF, 4'hF, 0);

        // Preload registers, decode them, then reset with a write-back pending.
        @(negedge clk);
        wb_valid = 1; wb_icode = 3; wb_dste = 2; wb_vale = 64'hAAAA;
        tick();
        wb_dste = 4; wb_vale = 64'hBBBB;
        tick();
        wb_valid = 0; wb_dste = 4'hF;
        in_valid = 1; icode = 6; ra = 2; rb = 4;
        tick();
        chk_all("preload", 1, 4'h6, 4'h0, 64'hAAAA, 64'hBBBB, 4'h4, 4'hF, 0);
        wb_valid = 1; wb_icode = 3; wb_dste = 2; wb_vale = 64'hCCCC;
        in_valid = 0;
        do_reset();
        wb_valid = 0; wb_dste = 4'hF;
        in_valid = 1; icode = 6; ra = 2; rb = 4;
        tick();
        chk_all("post_reset", 1, 4'h6, 4'h0, 64'h0, 64'h0, 4'h4, 4'hF, 0);
        idle_inputs();
        do_reset();

        // iv st ic ifn ra rb | wv wic wde wdm wve wvm wc | ov ic if va vb de dm h
        add(0,0,4'h0,4'h0,4'h0,4'h0, 1,4'h3,4'h2,4'hF,64'h1234,64'h0,0, 0,4'h0,4'h0,64'h0,64'h0,4'hF,4'hF,0);
        add(1,0,4'h6,4'h0,4'h2,4'h2, 0,4'h0,4'hF,4'hF,64'h0,64'h0,0,    1,4'h6,4'h0,64'h1234,64'h1234,4'h2,4'hF,0);
        add(0,0,4'h0,4'h0,4'h0,4'h0, 1,4'h2,4'h3,4'hF,64'h55,64'h0,0,   0,4'h6,4'h0,64'h1234,64'h1234,4'h2,4'hF,0);
        add(1,0,4'h2,4'h0,4'h3,4'h7, 0,4'h0,4'hF,4'hF,64'h0,64'h0,0,    1,4'h2,4'h0,64'h0,64'h0,4'h7,4'hF,0);
        add(0,0,4'h0,4'h0,4'h0,4'h0, 1,4'h2,4'h3,4'hF,64'h55,64'h0,1,   0,4'h2,4'h0,64'h0,64'h0,4'h7,4'hF,0);
        add(1,0,4'h2,4'h0,4'h3,4'h7, 0,4'h0,4'hF,4'hF,64'h0,64'h0,0,    1,4'h2,4'h0,64'h55,64'h0,4'h7,4'hF,0);
        add(1,0,4'hB,4'h0,4'h6,4'hF, 1,4'hB,4'h4,4'h4,64'h10,64'h20,1,  1,4'hB,4'h0,POP_RSP,POP_RSP,4'h4,4'h6,0);
        add(1,0,4'hB,4'h0,4'h6,4'hF, 0,4'h0,4'hF,4'hF,64'h0,64'h0,0,    1,4'hB,4'h0,64'h20,64'h20,4'h4,4'h6,0);
        add(1,0,4'h6,4'h1,4'h2,4'h3, 0,4'h0,4'hF,4'hF,64'h0,64'h0,0,    1,4'h6,4'h1,64'h1234,64'h55,4'h3,4'hF,0);
        add(1,1,4'hA,4'h0,4'h4,4'h4, 0,4'h0,4'hF,4'hF,64'h0,64'h0,0,    1,4'h6,4'h1,64'h1234,64'h55,4'h3,4'hF,0);
        add(0,1,4'hA,4'h3,4'h4,4'h4, 0,4'h0,4'hF,4'hF,64'h0,64'h0,0,    1,4'h6,4'h1,64'h1234,64'h55,4'h3,4'hF,0);
        add(1,1,4'h5,4'h2,4'h1,4'h1, 1,4'h3,4'h9,4'hF,64'h99,64'h0,0,   1,4'h6,4'h1,64'h1234,64'h55,4'h3,4'hF,0);
        add(1,0,4'hA,4'h0,4'h2,4'hF, 0,4'h0,4'hF,4'hF,64'h0,64'h0,0,    1,4'hA,4'h0,64'h1234,64'h20,4'h4,4'hF,0);
        add(1,0,4'h8,4'h0,4'hF,4'hF, 0,4'h0,4'hF,4'hF,64'h0,64'h0,0,    1,4'h8,4'h0,64'h0,64'h20,4'h4,4'hF,0);
        add(1,0,4'h5,4'h0,4'h1,4'h9, 0,4'h0,4'hF,4'hF,64'h0,64'h0,0,    1,4'h5,4'h0,64'h0,64'h99,4'hF,4'h1,0);
        add(1,0,4'h1,4'h0,4'h2,4'h3, 0,4'h0,4'hF,4'hF,64'h0,64'h0,0,    1,4'h1,4'h0,64'h0,64'h0,4'hF,4'hF,0);
        add(1,0,4'h0,4'h0,4'h2,4'h3, 0,4'h0,4'hF,4'hF,64'h0,64'h0,0,    1,4'h0,4'h0,64'h0,64'h0,4'hF,4'hF,1);
        add(1,0,4'h6,4'h0,4'h2,4'h2, 1,4'h6,4'h5,4'hF,64'h77,64'h0,1,   0,4'h0,4'h0,64'h0,64'h0,4'hF,4'hF,1);
        add(1,0,4'h6,4'h0,4'h9,4'h9, 0,4'h0,4'hF,4'hF,64'h0,64'h0,0,    0,4'h0,4'h0,64'h0,64'h0,4'hF,4'hF,1);

        foreach (tbl[k]) begin
            in_valid = tbl[k].iv; stall = tbl[k].st; icode = tbl[k].ic; ifun = tbl[k].ifn;
            ra = tbl[k].ra; rb = tbl[k].rb;
            wb_valid = tbl[k].wv; wb_icode = tbl[k].wic; wb_dste = tbl[k].wde; wb_dstm = tbl[k].wdm;
            wb_vale = tbl[k].wve; wb_valm = tbl[k].wvm; wb_cnd = tbl[k].wc;
            tick();
            chk_all($sformatf("vec%0d", k), tbl[k].e_ov, tbl[k].e_ic, tbl[k].e_if,
                    tbl[k].e_va, tbl[k].e_vb, tbl[k].e_de, tbl[k].e_dm, tbl[k].e_h);
        end
        idle_inputs();
        tick();
        chk("halted_wb_reg5", dut.regs_q[5], 64'h77);
        chk("halted_sticky", 64'(halted), 64'h1);
        do_reset();
        chk("reset_clears_reg5", dut.regs_q[5], 64'h0);

        // Randomized run against the reference model.
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 3) == 0);
            icode    = 4'($urandom_range(1, 15));
            if (c > 2600 && $urandom_range(0, 149) == 0) icode = 4'h0;
            ifun     = 4'($urandom);
            ra       = 4'($urandom);
            rb       = 4'($urandom);
            wb_valid = ($urandom_range(0, 2) != 0);
            wb_icode = ($urandom_range(0, 2) == 0) ? 4'h2 : 4'($urandom);
            wb_dste  = 4'($urandom);
            wb_dstm  = ($urandom_range(0, 3) == 0) ? wb_dste : 4'($urandom);
            wb_vale  = {$urandom, $urandom};
            wb_valm  = {$urandom, $urandom};
            wb_cnd   = 1'($urandom);
            model_step();
            tick();
            chk_all("rnd", m_ov, m_ic, m_if, m_va, m_vb, m_de, m_dm, m_h);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/y86_decode_regfile.md
Name: y86_decode_regfile

Overview:
- Decode/write-back stage of the Y86-64 datapath.
- Holds the 15 program registers and decodes icode/rA/rB into register IDs.
- Reads valA/valB and registers them for the execute stage, one cycle later.
- Accepts the execute/memory results (valE, valM, cnd) and writes them back; this is the producer of the execute stage's operands and the consumer of its results.

Parameters:
- N, 64, data width of registers, valA/valB, valE/valM.
- NREG, 15, number of architectural registers (IDs 0..14); ID 15 = RNONE.
- RSP_ID, 4, register ID of %rsp.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  decode request this cycle.
- stall  input  1  hold the decode output registers.
- icode  input  4  instruction code.
- ifun  input  4  function code, passed through.
- rA  input  4  register specifier A.
- rB  input  4  register specifier B.
- wb_valid  input  1  write-back request.
- wb_icode  input  4  icode of the retiring instruction.
- wb_dstE  input  4  E destination ID.
- wb_dstM  input  4  M destination ID.
- wb_valE  input  N  ALU result.
- wb_valM  input  N  memory result.
- wb_cnd  input  1  condition flag from execute.
- out_valid  output  1  decode outputs valid.
- out_icode  output  4  registered icode.
- out_ifun  output  4  registered ifun.
- valA  output  N  registered operand A.
- valB  output  N  registered operand B.
- dstE  output  4  registered E destination.
- dstM  output  4  registered M destination.
- halted  output  1  halt state flag.

Behaviour:
- Reset (reset low, asynchronous): all 15 registers = 0; out_valid=0; out_icode=0; out_ifun=0; valA=0; valB=0; dstE=15; dstM=15; halted=0; state=RUN.
- Reset mid-operation clears everything immediately, including any pending write.
- srcA (combinational):
  - rA for icode 2, 4, 6, A.
  - RSP_ID for icode 9, B.
  - Otherwise 15.
- srcB (combinational):
  - rB for icode 4, 5, 6.
  - RSP_ID for icode 8, 9, A, B.
  - Otherwise 15.
- dstE (decoded):
  - rB for icode 2, 3, 6.
  - RSP_ID for icode 8, 9, A, B.
  - Otherwise 15.
- dstM (decoded): rA for icode 5, B; otherwise 15.
- Register read:
  - ID 15 reads as 0.
  - Any rA/rB value is legal; there are no out-of-range IDs.
- Decode latency is 1 cycle:
  - At a clock edge with in_valid=1, stall=0 and state RUN, latch out_icode, out_ifun, valA, valB, dstE, dstM, and set out_valid=1.
  - With in_valid=0, stall=0: out_valid goes to 0; data outputs hold.
  - With stall=1: all outputs, including out_valid, hold.
- Write-back (at a clock edge, when wb_valid=1):
  - E-port writes wb_valE to wb_dstE, unless wb_dstE=15.
  - For wb_icode=2 (rrmovq/cmovXX) with wb_cnd=0, the E write is suppressed.
  - M-port writes wb_valM to wb_dstM, unless wb_dstM=15.
  - If wb_dstE == wb_dstM (both ≠15), the M-port wins (popq %rsp semantics).
- Write-back proceeds regardless of stall or state.
- State machine:
  - RUN: decoding a valid icode 0 (halt) latches normally and moves to HALTED; halted=1 from the next cycle.
  - RUN: icode 1 (nop) latches with both dst=15.
  - HALTED: in_valid is ignored and out_valid=0 from the first HALTED edge; write-back still completes.
  - HALTED is left only via reset.
- Simultaneous read and write of the same register in one cycle: see Optional Feature.

Optional Feature:
- Macro YRF_WRITE_THROUGH_EN.
- Defined: the read path forwards the same-cycle write-back data. Priority is M-port, then E-port, then stored value, so valA/valB latch the new value.
- Undefined: reads return the pre-edge stored value; the new value is visible from the next decode.

Test Plan:
- Reset with registers preloaded -> valA=valB=0, dstE=dstM=15, out_valid=0, halted=0.
- Write back irmovq (wb_icode=3, dstE=2, valE=0x1234), then decode OPq (icode 6, rA=2, rB=2) -> valA=valB=0x1234, dstE=2, out_valid=1 one cycle after in_valid.
- wb_icode=2, dstE=3, valE=0x55, wb_cnd=0, then decode rA=3 -> valA=0. Repeat with wb_cnd=1 -> valA=0x55.
- Simultaneous write-back and decode:
  - wb dstE=4 (0x10) and dstM=4 (0x20) together -> %rsp=0x20.
  - Decode popq (icode B) in the same cycle -> valA=valB=0x20 with YRF_WRITE_THROUGH_EN defined, old %rsp without it.
- Stall=1 for 3 cycles with changing inputs -> all outputs stable. Release -> new decode appears 1 cycle later.
- Decode icode 0 -> halted=1 the next cycle. Further in_valid=1 (icode 6) -> out_valid=0. A write-back to reg 5 still lands. Reset low -> halted=0.
